// File: rtl/medipix_pkg.sv
// Shared definitions for the Medipix command streamer: FSM encoding,
// default sizing constants, FIFO entry layout and the byte-order helper.
package medipix_pkg;

    // Serialiser FSM encoding
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    localparam int DEF_FIFO_DEPTH = 8;
    localparam int DEF_BYTE_GAP   = 1;

    // FIFO entry is {last, word}
    localparam int ENTRY_W = 33;

    // Bytes leave MSB first, so the index starts at the top byte
    localparam logic [1:0] FIRST_BYTE_IDX = 2'd3;

    // Select byte 'idx' of a 32-bit word (idx 3 = bits 31:24)
    function automatic logic [7:0] sel_byte(input logic [31:0] w, input logic [1:0] idx);
        return w[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/medipix_cmd_fifo.sv
// Command-word FIFO for the Medipix streamer. Registered full/empty flags,
// simultaneous push/pop allowed (a push into a full FIFO is accepted when a
// pop happens in the same cycle). 'drop' flags a push that was refused.
module medipix_cmd_fifo
    import medipix_pkg::*;
#(
    parameter int DEPTH = DEF_FIFO_DEPTH,
    parameter int WIDTH = ENTRY_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic             drop
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign pop_ok_s  = pop && !empty_q;
    assign push_ok_s = push && (!full_q || pop_ok_s);

    // Pointer, occupancy and flag update; pointers wrap naturally at DEPTH
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
        full_d  = (cnt_d == FULL_CNT);
        empty_d = (cnt_d == {(AW+1){1'b0}});
    end

    // Control state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            cnt_q    <= {(AW+1){1'b0}};
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage array; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = full_q;
    assign empty = empty_q;
    assign drop  = push && full_q && !pop_ok_s;

endmodule

// File: rtl/medipix_cmd_streamer.sv
// Medipix command streamer: buffers 32-bit command words from the Nios PIO
// and serialises them MSB byte first toward Medipix_Bridge, with BYTE_GAP
// idle cycles after every byte and a sync marker on each frame's first byte.
// Optional feature: define MDPX_FRAME_CHECKSUM_EN to append an XOR checksum
// byte after the last word of every frame.
module medipix_cmd_streamer
    import medipix_pkg::*;
#(
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int BYTE_GAP   = DEF_BYTE_GAP
) (
    input  logic        In_Clk,
    input  logic        In_Reset,
    input  logic        In_Wr_nios,
    input  logic [31:0] In_Word_nios,
    input  logic        In_Last_nios,
    input  logic        In_Clr_Ovf,
    output logic        Out_En_nios,
    output logic        Out_Sync_nios,
    output logic [7:0]  Out_Data_nios,
    output logic        Out_Full,
    output logic        Out_Empty,
    output logic        Out_Overflow,
    output logic        Out_Busy
);

    localparam logic       GAP_EN   = (BYTE_GAP != 0);
    localparam logic [7:0] GAP_LOAD = 8'(BYTE_GAP - 1);

    state_t              state_q, state_d;
    logic [31:0]         sr_q, sr_d;
    logic [1:0]          idx_q, idx_d;
    logic                last_q, last_d;
    logic [7:0]          gap_q, gap_d;
    logic                frame_start_q, frame_start_d;
    logic                out_en_q, out_en_d;
    logic                out_sync_q, out_sync_d;
    logic [7:0]          out_data_q, out_data_d;
    logic                busy_q, busy_d;
    logic                ovf_q, ovf_d;
`ifdef MDPX_FRAME_CHECKSUM_EN
    logic [7:0]          cks_q, cks_d;
    logic                cks_phase_q, cks_phase_d;
`endif

    logic [ENTRY_W-1:0]  fifo_rdata_s;
    logic                fifo_full_s;
    logic                fifo_empty_s;
    logic                fifo_drop_s;
    logic                fifo_pop_s;
    logic                more_s;
    logic                after_byte_s;
    logic                emit_s;
    logic                emit_data_s;
    logic [7:0]          emit_byte_s;

    assign fifo_pop_s = (state_q == ST_LOAD);

    medipix_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (In_Clk),
        .rst   (In_Reset),
        .push  (In_Wr_nios),
        .wdata ({In_Last_nios, In_Word_nios}),
        .pop   (fifo_pop_s),
        .rdata (fifo_rdata_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .drop  (fifo_drop_s)
    );

    // Another byte follows the current one: lower data byte, or the checksum
`ifdef MDPX_FRAME_CHECKSUM_EN
    assign more_s = (idx_q != 2'd0) || (last_q && !cks_phase_q);
`else
    assign more_s = (idx_q != 2'd0);
`endif

    // The current byte (and its gap) is complete this cycle
    assign after_byte_s = ((state_q == ST_SHIFT) && !GAP_EN) ||
                          ((state_q == ST_GAP) && (gap_q == 8'd0));

    // FSM state register
    always_ff @(posedge In_Clk or posedge In_Reset) begin
        if (In_Reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection for the byte serialiser
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty_s) state_d = ST_LOAD;
                else               state_d = ST_IDLE;
            end
            ST_LOAD: state_d = ST_SHIFT;
            ST_SHIFT: begin
                if (GAP_EN)      state_d = ST_GAP;
                else if (more_s) state_d = ST_SHIFT;
                else             state_d = ST_IDLE;
            end
            ST_GAP: begin
                if (gap_q != 8'd0) state_d = ST_GAP;
                else if (more_s)   state_d = ST_SHIFT;
                else               state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath and registered-output computation; outputs are loaded on the
    // edge that enters SHIFT so Out_En_nios is high during the SHIFT cycle
    always_comb begin
        sr_d          = sr_q;
        idx_d         = idx_q;
        last_d        = last_q;
        gap_d         = gap_q;
        frame_start_d = frame_start_q;
        out_en_d      = 1'b0;
        out_sync_d    = 1'b0;
        out_data_d    = out_data_q;
        emit_s        = 1'b0;
        emit_data_s   = 1'b0;
        emit_byte_s   = 8'h00;
`ifdef MDPX_FRAME_CHECKSUM_EN
        cks_d         = cks_q;
        cks_phase_d   = cks_phase_q;
`endif
        if (state_q == ST_LOAD) begin
            sr_d        = fifo_rdata_s[31:0];
            last_d      = fifo_rdata_s[32];
            idx_d       = FIRST_BYTE_IDX;
            emit_s      = 1'b1;
            emit_data_s = 1'b1;
            emit_byte_s = sel_byte(fifo_rdata_s[31:0], FIRST_BYTE_IDX);
`ifdef MDPX_FRAME_CHECKSUM_EN
            cks_phase_d = 1'b0;
`endif
        end else if ((state_q == ST_SHIFT) && GAP_EN) begin
            gap_d = GAP_LOAD;
        end else if ((state_q == ST_GAP) && (gap_q != 8'd0)) begin
            gap_d = gap_q - 8'd1;
        end else if (after_byte_s) begin
            if (idx_q != 2'd0) begin
                idx_d       = idx_q - 2'd1;
                emit_s      = 1'b1;
                emit_data_s = 1'b1;
                emit_byte_s = sel_byte(sr_q, idx_q - 2'd1);
            end else begin
                // Word finished: a last-flagged word closes the frame
                if (last_q) frame_start_d = 1'b1;
                else        frame_start_d = frame_start_q;
`ifdef MDPX_FRAME_CHECKSUM_EN
                if (last_q && !cks_phase_q) begin
                    cks_phase_d = 1'b1;
                    emit_s      = 1'b1;
                    emit_byte_s = cks_q;
                end else begin
                    cks_phase_d = 1'b0;
                end
`endif
            end
        end else begin
            gap_d = gap_q;
        end

        if (emit_s) begin
            out_en_d   = 1'b1;
            out_data_d = emit_byte_s;
            if (emit_data_s) begin
                out_sync_d    = frame_start_q;
                frame_start_d = 1'b0;
`ifdef MDPX_FRAME_CHECKSUM_EN
                cks_d = frame_start_q ? emit_byte_s : (cks_q ^ emit_byte_s);
`endif
            end else begin
                out_sync_d = 1'b0;
            end
        end else begin
            out_en_d = 1'b0;
        end

        busy_d = (state_d != ST_IDLE);

        // Refused write sets the sticky flag; set beats clear
        if (fifo_drop_s)      ovf_d = 1'b1;
        else if (In_Clr_Ovf)  ovf_d = 1'b0;
        else                  ovf_d = ovf_q;
    end

    // Datapath and output registers
    always_ff @(posedge In_Clk or posedge In_Reset) begin
        if (In_Reset) begin
            sr_q          <= 32'h0000_0000;
            idx_q         <= 2'd0;
            last_q        <= 1'b0;
            gap_q         <= 8'd0;
            frame_start_q <= 1'b1;
            out_en_q      <= 1'b0;
            out_sync_q    <= 1'b0;
            out_data_q    <= 8'h00;
            busy_q        <= 1'b0;
            ovf_q         <= 1'b0;
`ifdef MDPX_FRAME_CHECKSUM_EN
            cks_q         <= 8'h00;
            cks_phase_q   <= 1'b0;
`endif
        end else begin
            sr_q          <= sr_d;
            idx_q         <= idx_d;
            last_q        <= last_d;
            gap_q         <= gap_d;
            frame_start_q <= frame_start_d;
            out_en_q      <= out_en_d;
            out_sync_q    <= out_sync_d;
            out_data_q    <= out_data_d;
            busy_q        <= busy_d;
            ovf_q         <= ovf_d;
`ifdef MDPX_FRAME_CHECKSUM_EN
            cks_q         <= cks_d;
            cks_phase_q   <= cks_phase_d;
`endif
        end
    end

    assign Out_En_nios   = out_en_q;
    assign Out_Sync_nios = out_sync_q;
    assign Out_Data_nios = out_data_q;
    assign Out_Full      = fifo_full_s;
    assign Out_Empty     = fifo_empty_s;
    assign Out_Overflow  = ovf_q;
    assign Out_Busy      = busy_q;

endmodule

// File: doc/medipix_cmd_streamer.md
MEDIPIX_CMD_STREAMER -- requirements
Module: medipix_cmd_streamer

Interface
REQ-001 Parameter: FIFO_DEPTH, 8, number of 32-bit command words buffered; power of two, 2..64.
REQ-002 Parameter: BYTE_GAP, 1, idle clock cycles inserted after every emitted byte; range 0..255.
REQ-003 Port: In_Clk  input  1  sole clock; all logic on its rising edge.
REQ-004 Port: In_Reset  input  1  asynchronous, active-high reset.
REQ-005 Port: In_Wr_nios  input  1  one-cycle write strobe from Nios PIO.
REQ-006 Port: In_Word_nios  input  32  command word, sampled when In_Wr_nios=1.
REQ-007 Port: In_Last_nios  input  1  marks the written word as last of its frame.
REQ-008 Port: In_Clr_Ovf  input  1  clears Out_Overflow.
REQ-009 Port: Out_En_nios  output  1  byte-valid strobe toward Medipix_Bridge In_En_nios.
REQ-010 Port: Out_Sync_nios  output  1  first-byte-of-frame marker toward In_Sync_nios.
REQ-011 Port: Out_Data_nios  output  8  byte toward In_Data_nios.
REQ-012 Port: Out_Full, Out_Empty  output  1 each  FIFO status, registered.
REQ-013 Port: Out_Overflow  output  1  sticky write-while-full flag.
REQ-014 Port: Out_Busy  output  1  high whenever FSM is not IDLE.

Function
REQ-015 FIFO stores {last, word}; a write accepted when not full, or when full and a pop occurs in the same cycle.
REQ-016 Write while full with no same-cycle pop: word dropped, Out_Overflow set next cycle; stays set until In_Clr_Ovf=1; set wins over simultaneous clear.
REQ-017 FSM states: IDLE, LOAD, SHIFT, GAP.
REQ-018 IDLE -> LOAD when FIFO not empty; LOAD pops one entry into a 32-bit shift register and a 2-bit byte index set to 3.
REQ-019 LOAD -> SHIFT; SHIFT drives Out_Data_nios = word[8*idx+7:8*idx] (MSB byte first) with Out_En_nios=1 for exactly one cycle.
REQ-020 SHIFT -> GAP when BYTE_GAP>0, GAP lasts BYTE_GAP cycles with Out_En_nios=0; with BYTE_GAP=0 the GAP state is skipped.
REQ-021 After a byte with idx>0: decrement idx, return to SHIFT; after idx=0: go to IDLE (or, with checksum enabled and word last, emit checksum first).
REQ-022 Out_Sync_nios=1 only together with Out_En_nios on the first byte after reset or after the final byte of a last-flagged word.
REQ-023 Latency: word written at edge k into an empty FIFO with FSM idle -> Out_En_nios high in the cycle following edge k+2.
REQ-024 Out_Data_nios holds last value when Out_En_nios=0; Out_En_nios, Out_Sync_nios, Out_Data_nios registered.
REQ-025 Pointers wrap modulo FIFO_DEPTH; Out_Full/Out_Empty exact at wrap boundary.

Reset
REQ-026 In_Reset=1 asynchronously clears FIFO pointers, FSM to IDLE, shift register, idx, checksum, frame-start flag set to 1.
REQ-027 Reset values: Out_En_nios=0, Out_Sync_nios=0, Out_Data_nios=8'h00, Out_Full=0, Out_Empty=1, Out_Overflow=0, Out_Busy=0.
REQ-028 Reset mid-frame discards buffered words and partial frame; no byte emitted in the reset cycle.

Configuration
REQ-029 Macro MDPX_FRAME_CHECKSUM_EN defined: after the final byte (and its gap) of a last-flagged word, one extra byte = XOR of all frame bytes is emitted with Out_En_nios=1, Out_Sync_nios=0, followed by BYTE_GAP idle cycles; checksum cleared at frame start.
REQ-030 Macro undefined: no checksum logic; frame ends after its final data byte.

Structure
REQ-031 Shared package medipix_pkg holds FSM state encoding, default FIFO_DEPTH and BYTE_GAP constants, byte-order constant.
REQ-032 FIFO implemented as sub-module medipix_cmd_fifo (registered full/empty, same-cycle push/pop).

Verification
REQ-033 Write 32'hA1B2C3D4 last=1, BYTE_GAP=1 -> bytes A1,B2,C3,D4 on cycles n, n+2, n+4, n+6; Sync only with A1.
REQ-034 Nine writes back-to-back, FIFO_DEPTH=8, FSM idle initially -> no overflow; tenth write with FIFO full -> Out_Overflow=1, word lost; In_Clr_Ovf clears it.
REQ-035 Two frames {11223344 last=0, 55667788 last=1}, {99AABBCC last=1} -> Sync on 11 and 99 only.
REQ-036 MDPX_FRAME_CHECKSUM_EN, word 01020304 last=1 -> bytes 01,02,03,04, then 04 with Sync=0.
REQ-037 Assert In_Reset during byte C3 of a frame -> outputs zero immediately, Out_Empty=1; next write restarts with Sync=1.
